// File: rtl/uart_pkg.sv
// uart_pkg
//   Encodings shared by the UART receive path, the transmit path and the
//   config register B fields.
//   Contents:
//     parity_type_t      parity selection (NONE, ODD, EVEN, NONE2)
//     uart_rx_state_t    receive FSM states
//     UART_MIN_DATA_BITS the character width encoded by data_bits_count = 0
//     parity_enabled()   true for ODD or EVEN
package uart_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        ODD   = 2'd1,
        EVEN  = 2'd2,
        NONE2 = 2'd3
    } parity_type_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } uart_rx_state_t;

    localparam int UART_MIN_DATA_BITS = 5;

    function automatic logic parity_enabled(input parity_type_t p);
        return (p == ODD) || (p == EVEN);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for asynchronous inputs, with a selectable reset
//   value so idle-high lines do not glitch low when reset is released.
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high reset (both flops load RESET_VAL)
//     i_d    asynchronous input
//     o_q    synchronized output, two clk cycles behind i_d
module sync_2ff #(
    parameter int                WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx
//   UART receive deserializer. Oversamples the rx line on sample_tick,
//   confirms the start bit at its midpoint, then samples 5-8 data bits
//   (LSB first), an optional parity bit and 1 or 2 stop bits, each at
//   mid-bit. Each character is delivered as a one-clk valid strobe with
//   its parity and framing error flags.
//   Ports:
//     clk, reset         clock, synchronous active-high reset
//     sample_tick        one-clk enable at OVERSAMPLE x baud
//     rx                 asynchronous serial input, idle high
//     data_bits_count    data bits = value + 5
//     parity_type        00 none, 01 odd, 10 even, 11 none
//     double_stop_bits   1 = two stop bits
//     data               received character, right-aligned
//     valid              one-clk write strobe for the RX FIFO
//     parity_error       parity mismatch for the current data
//     frame_error        a stop bit was sampled low for the current data
//     busy               high from start-bit confirmation until frame end
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_tick,
    input  logic       rx,
    input  logic [1:0] data_bits_count,
    input  logic [1:0] parity_type,
    input  logic       double_stop_bits,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_error,
    output logic       frame_error,
    output logic       busy
);

    localparam int                TICK_W    = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] MID_START = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);

    uart_rx_state_t    r_state;
    uart_rx_state_t    w_next;
    logic              w_rx;
    logic [TICK_W-1:0] r_tick;
    logic [2:0]        r_bitcnt;
    logic [7:0]        r_shift;
    logic              r_par_acc;
    logic              r_par_err;
    logic              r_frm_err;
    logic [1:0]        r_dbc;
    parity_type_t      r_ptype;
    logic              r_dstop;
    logic [7:0]        r_data;
    logic              r_valid;
    logic              r_perr;
    logic              r_ferr;
    logic              w_bit_sample;
    logic              w_mid_start;
    logic              w_last_data;
    logic              w_frame_end;
    logic [2:0]        w_top_pos;

    // New bit lands at the top of the configured width; earlier bits move down.
    function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic b,
                                            input logic [2:0] pos);
        logic [7:0] v;
        v      = sr >> 1;
        v[pos] = b;
        return v;
    endfunction

    // x is the XOR of all data bits and the received parity bit.
    function automatic logic parity_mismatch(input parity_type_t p, input logic x);
        return ((p == ODD) && !x) || ((p == EVEN) && x);
    endfunction

    sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rx)
    );

    assign w_top_pos    = {1'b0, r_dbc} + 3'd4;
    assign w_bit_sample = sample_tick && (r_tick == LAST_TICK);
    assign w_mid_start  = sample_tick && (r_tick == MID_START);
    assign w_last_data  = (r_bitcnt == w_top_pos);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (sample_tick && !w_rx) w_next = START;
            START:   if (w_mid_start) w_next = w_rx ? IDLE : DATA;
            DATA:    if (w_bit_sample && w_last_data)
                         w_next = parity_enabled(r_ptype) ? PARITY : STOP1;
            PARITY:  if (w_bit_sample) w_next = STOP1;
            STOP1:   if (w_bit_sample) w_next = r_dstop ? STOP2 : IDLE;
            STOP2:   if (w_bit_sample) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Frame end is the last stop-bit sample; the FSM is back in IDLE by then,
    // so a start edge right after the stop bit is caught without a gap.
    always_comb begin
        busy        = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            DATA, PARITY: busy = 1'b1;
            STOP1: begin
                busy        = 1'b1;
                w_frame_end = w_bit_sample && !r_dstop;
            end
            STOP2: begin
                busy        = 1'b1;
                w_frame_end = w_bit_sample;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick    <= '0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_par_acc <= 1'b0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_dbc     <= '0;
            r_ptype   <= NONE;
            r_dstop   <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (sample_tick) begin
                // Free-running modulo-OVERSAMPLE counter; mid-bit samples
                // fall on LAST_TICK once START has realigned it.
                r_tick <= r_tick + TICK_W'(1);
                case (r_state)
                    IDLE: begin
                        r_tick <= '0;
                        if (!w_rx) begin
                            r_bitcnt  <= '0;
                            r_shift   <= '0;
                            r_par_acc <= 1'b0;
                            r_par_err <= 1'b0;
                            r_frm_err <= 1'b0;
                            r_dbc     <= data_bits_count;
                            r_ptype   <= parity_type_t'(parity_type);
                            r_dstop   <= double_stop_bits;
                        end
                    end
                    START: if (r_tick == MID_START) r_tick <= '0;
                    DATA: if (r_tick == LAST_TICK) begin
                        r_shift   <= shift_in(r_shift, w_rx, w_top_pos);
                        r_par_acc <= r_par_acc ^ w_rx;
                        r_bitcnt  <= r_bitcnt + 3'd1;
                    end
                    PARITY: if (r_tick == LAST_TICK)
                        r_par_err <= parity_mismatch(r_ptype, r_par_acc ^ w_rx);
                    STOP1: if (r_tick == LAST_TICK) r_frm_err <= !w_rx;
                    default: ;
                endcase
            end
            if (w_frame_end) begin
                r_data  <= r_shift;
                r_perr  <= r_par_err;
                r_ferr  <= (r_state == STOP2) ? (r_frm_err | !w_rx) : !w_rx;
                r_valid <= 1'b1;
            end
        end
    end

    assign data         = r_data;
    assign valid        = r_valid;
    assign parity_error = r_perr;
    assign frame_error  = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_tick = 1'b0;
    logic       rx = 1'b1;
    logic [1:0] data_bits_count = 2'd3;
    logic [1:0] parity_type = 2'd0;
    logic       double_stop_bits = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       parity_error;
    logic       frame_error;
    logic       busy;

    uart_rx #(.OVERSAMPLE(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .sample_tick      (sample_tick),
        .rx               (rx),
        .data_bits_count  (data_bits_count),
        .parity_type      (parity_type),
        .double_stop_bits (double_stop_bits),
        .data             (data),
        .valid            (valid),
        .parity_error     (parity_error),
        .frame_error      (frame_error),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         t;
    } rec_t;

    int   n_checks = 0;
    int   n_fail = 0;
    int   tick_div = 4;
    int   ticks_seen = 0;
    bit   busy_seen = 0;
    bit   cfg_scramble = 0;
    rec_t obs_q[$];

    // Tick source: one clk-wide pulse every tick_div clocks.
    initial begin : tickgen
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            sample_tick = (cnt == 0);
            cnt = (cnt + 1 >= tick_div) ? 0 : cnt + 1;
        end
    end

    always @(posedge clk) if (sample_tick) ticks_seen <= ticks_seen + 1;

    always @(negedge clk) begin : mon
        rec_t r;
        if (valid) begin
            r.d  = data;
            r.pe = parity_error;
            r.fe = frame_error;
            r.t  = ticks_seen;
            obs_q.push_back(r);
        end
        if (busy) busy_seen = 1'b1;
    end

    initial begin : watchdog
        #800us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clk);
            if (sample_tick) k++;
        end
        #1;
    endtask

    task automatic hold(input logic lvl, input int n);
        rx = lvl;
        wait_ticks(n);
    endtask

    // Line-level frame built from the framing rules: start, LSB-first data,
    // optional parity (even: XOR of data, odd: its inverse), stop bit(s).
    task automatic send_frame(input logic [7:0] d, input int nb, input logic [1:0] pt,
                              input logic ds, input bit flip, input bit s1low, input bit s2low);
        logic [7:0] m;
        logic       pbit;
        m = 8'((1 << nb) - 1);
        hold(1'b0, 16);
        if (cfg_scramble) begin
            data_bits_count  = data_bits_count ^ 2'b11;
            parity_type      = (parity_type == 2'd0) ? 2'd2 : 2'd0;
            double_stop_bits = ~double_stop_bits;
        end
        for (int i = 0; i < nb; i++) hold(d[i], 16);
        if (pt == 2'd1 || pt == 2'd2) begin
            pbit = (pt == 2'd2) ? ^(d & m) : ~^(d & m);
            if (flip) pbit = ~pbit;
            hold(pbit, 16);
        end
        hold(~s1low, 16);
        if (ds) hold(~s2low, 16);
        rx = 1'b1;
    endtask

    task automatic run_frame(input logic [7:0] d, input int nb, input logic [1:0] pt,
                             input logic ds, input bit flip, input bit s1, input bit s2,
                             input string tag);
        logic [7:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
        rec_t       r;
        exp_d  = d & 8'((1 << nb) - 1);
        exp_pe = (pt == 2'd1 || pt == 2'd2) && flip;
        exp_fe = s1 || (ds && s2);
        data_bits_count  = 2'(nb - 5);
        parity_type      = pt;
        double_stop_bits = ds;
        obs_q.delete();
        send_frame(d, nb, pt, ds, flip, s1, s2);
        hold(1'b1, (s1 || s2) ? 24 : 4);
        chk({tag, " count"}, obs_q.size(), 1);
        if (obs_q.size() > 0) begin
            r = obs_q.pop_front();
            chk({tag, " data"}, r.d, exp_d);
            chk({tag, " parity_error"}, r.pe, exp_pe);
            chk({tag, " frame_error"}, r.fe, exp_fe);
        end
    endtask

    initial begin : main
        rec_t       r1;
        rec_t       r2;
        logic [7:0] rd;
        int         nb;
        logic [1:0] pt;
        logic       ds;
        bit         fl;
        bit         s1;
        bit         s2;

        // Reset state
        repeat (4) @(posedge clk);
        #1;
        chk("reset data", data, 8'h00);
        chk("reset valid", valid, 1'b0);
        chk("reset parity_error", parity_error, 1'b0);
        chk("reset frame_error", frame_error, 1'b0);
        chk("reset busy", busy, 1'b0);
        reset = 1'b0;
        hold(1'b1, 20);

        // 8N1 back-to-back, tick every 4 clk
        tick_div = 4;
        data_bits_count = 2'd3; parity_type = 2'd0; double_stop_bits = 1'b0;
        obs_q.delete();
        send_frame(8'hA5, 8, 2'd0, 1'b0, 0, 0, 0);
        send_frame(8'h3C, 8, 2'd0, 1'b0, 0, 0, 0);
        hold(1'b1, 4);
        chk("b2b count", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            r1 = obs_q.pop_front();
            r2 = obs_q.pop_front();
            chk("b2b data0", r1.d, 8'hA5);
            chk("b2b data1", r2.d, 8'h3C);
            chk("b2b errors", {r1.pe, r1.fe, r2.pe, r2.fe}, 4'b0000);
            chk("b2b spacing", r2.t - r1.t, 160);
        end

        // Formats and parity
        run_frame(8'h55, 7, 2'd2, 1'b1, 0, 0, 0, "7E2");
        run_frame(8'h1F, 5, 2'd1, 1'b0, 0, 0, 0, "5O1");
        run_frame(8'h01, 8, 2'd2, 1'b0, 1, 0, 0, "bad parity");

        // Framing errors
        run_frame(8'h3C, 8, 2'd0, 1'b0, 0, 1, 0, "stop low");
        run_frame(8'h96, 8, 2'd0, 1'b1, 0, 0, 1, "stop2 low");

        // sample_tick high on every clk
        tick_div = 1;
        run_frame(8'h6B, 8, 2'd1, 1'b0, 0, 0, 0, "tick every clk");
        tick_div = 4;
        hold(1'b1, 8);

        // False start: 3-tick low glitch
        obs_q.delete();
        busy_seen = 0;
        hold(1'b0, 3);
        hold(1'b1, 30);
        chk("glitch3 count", obs_q.size(), 0);
        chk("glitch3 busy", busy_seen, 1'b0);

        // 1-clk glitch between ticks
        busy_seen = 0;
        rx = 1'b0;
        @(posedge clk);
        #1;
        rx = 1'b1;
        hold(1'b1, 30);
        chk("glitch1 count", obs_q.size(), 0);
        chk("glitch1 busy", busy_seen, 1'b0);

        // Leave non-zero outputs, then reset during data bit 4
        run_frame(8'hC6, 8, 2'd2, 1'b0, 1, 1, 0, "both errors");
        obs_q.delete();
        data_bits_count = 2'd3; parity_type = 2'd0; double_stop_bits = 1'b0;
        hold(1'b0, 16);
        rd = 8'h5A;
        for (int i = 0; i < 4; i++) hold(rd[i], 16);
        hold(rd[4], 8);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midreset data", data, 8'h00);
        chk("midreset valid", valid, 1'b0);
        chk("midreset parity_error", parity_error, 1'b0);
        chk("midreset frame_error", frame_error, 1'b0);
        chk("midreset busy", busy, 1'b0);
        reset = 1'b0;
        hold(1'b1, 40);
        chk("midreset no valid", obs_q.size(), 0);
        run_frame(8'h81, 8, 2'd0, 1'b0, 0, 0, 0, "after reset");

        // Config changes mid-frame are ignored
        cfg_scramble = 1;
        run_frame(8'hC3, 8, 2'd0, 1'b0, 0, 0, 0, "cfg change");
        cfg_scramble = 0;

        // Randomized frames
        for (int n = 0; n < 10; n++) begin
            case ($urandom_range(0, 2))
                0:       tick_div = 1;
                1:       tick_div = 2;
                default: tick_div = 4;
            endcase
            rd = 8'($urandom);
            nb = 5 + int'($urandom_range(0, 3));
            pt = 2'($urandom_range(0, 3));
            ds = 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 3) == 0);
            s1 = ($urandom_range(0, 4) == 0);
            s2 = ($urandom_range(0, 4) == 0);
            hold(1'b1, 4);
            run_frame(rd, nb, pt, ds, fl, s1, s2, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
